// File: rtl/ip_amba_apb_pkg.sv
// rtl/ip_amba_apb_pkg.sv - shared types and constants for the APB4 memory slave
package ip_amba_apb_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_state_e;

  // CSR offsets in bus words; byte offset is index * DATA_W/8
  localparam int unsigned CSR_BASE_IDX    = 0;
  localparam int unsigned CSR_ERR_CNT_IDX = 1;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_UNMAPPED  = 2'd1,
    ERR_UNALIGNED = 2'd2,
    ERR_PROT      = 2'd3
  } err_cause_e;

  typedef enum logic [1:0] {
    TGT_NONE    = 2'd0,
    TGT_BASE    = 2'd1,
    TGT_ERR_CNT = 2'd2,
    TGT_MEM     = 2'd3
  } tgt_e;

endpackage

// File: rtl/ip_amba_apb_bytemem.sv
// rtl/ip_amba_apb_bytemem.sv - byte-enable RAM, synchronous write, asynchronous read
module ip_amba_apb_bytemem #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH_LOG2 = 6
) (
  input  logic                    PCLK,
  input  logic [DEPTH_LOG2-1:0]   addr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic [DATA_W/8-1:0]     wstrb,
  input  logic                    we,
  input  logic [DEPTH_LOG2-1:0]   raddr,
  output logic [DATA_W-1:0]       rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge PCLK) begin
    if (we) begin
      for (int i = 0; i < int'(DATA_W/8); i++) begin
        if (wstrb[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ip_amba_apb4_mem_slave.sv
// rtl/ip_amba_apb4_mem_slave.sv - APB4 slave with BASE/ERR_CNT CSRs and a relocatable memory window
module ip_amba_apb4_mem_slave
  import ip_amba_apb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_DEPTH   = 6,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned BASE_RST    = 'h100,
  parameter bit          PROT_CHECK  = 1'b1
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_W-1:0]     PADDR,
  input  logic [2:0]            PPROT,
  input  logic [DATA_W-1:0]     PWDATA,
  input  logic [DATA_W/8-1:0]   PSTRB,
  output logic                  PREADY,
  output logic [DATA_W-1:0]     PRDATA,
  output logic                  PSLVERR
);

  localparam int unsigned       BYTES       = DATA_W / 8;
  localparam int unsigned       ALIGN_W     = $clog2(BYTES);
  localparam int unsigned       WIN_INT     = (1 << MEM_DEPTH) * BYTES;
  localparam logic [ADDR_W:0]   WIN_BYTES   = (ADDR_W+1)'(WIN_INT);
  localparam logic [ADDR_W-1:0] ALIGN_MASK  = ADDR_W'(BYTES - 1);
  localparam logic [ADDR_W-1:0] BASE_OFF    = ADDR_W'(CSR_BASE_IDX * BYTES);
  localparam logic [ADDR_W-1:0] ERR_CNT_OFF = ADDR_W'(CSR_ERR_CNT_IDX * BYTES);

  apb_state_e           state_q, state_d;
  logic [3:0]           wait_q;
  err_cause_e           cause_q, cause_d;
  tgt_e                 tgt_q, tgt_d;
  logic                 wr_q;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic [MEM_DEPTH-1:0] idx_q, idx_d;
  logic [DATA_W-1:0]    base_q;
  logic [15:0]          err_cnt_q;

  logic [ADDR_W-1:0]    base_addr, offset, idx_full;
  logic                 in_win, unaligned;
  logic [DATA_W-1:0]    mem_rdata;
  logic                 setup, pready, complete, err_q, commit;
  logic                 unused_bits;

  // Window test is done at ADDR_W+1 bits so a window running past the top of the address space never wraps
  always_comb begin
    base_addr = ADDR_W'(base_q);
    offset    = PADDR - base_addr;
    idx_full  = offset >> ALIGN_W;
    idx_d     = idx_full[MEM_DEPTH-1:0];
    in_win    = (PADDR >= base_addr) && ({1'b0, offset} < WIN_BYTES);
    unaligned = |(PADDR & ALIGN_MASK);
    tgt_d     = TGT_NONE;
    cause_d   = ERR_NONE;
    rdata_d   = '0;
    if (PADDR == BASE_OFF) begin
      tgt_d   = TGT_BASE;
      rdata_d = base_q;
    end else if (PADDR == ERR_CNT_OFF) begin
      tgt_d   = TGT_ERR_CNT;
      rdata_d = DATA_W'(err_cnt_q);
    end else if (in_win) begin
      tgt_d   = TGT_MEM;
      rdata_d = mem_rdata;
    end
    if (unaligned)
      cause_d = ERR_UNALIGNED;
    else if (tgt_d == TGT_NONE)
      cause_d = ERR_UNMAPPED;
    else if (tgt_d != TGT_MEM && PWRITE && PROT_CHECK && !PPROT[0])
      cause_d = ERR_PROT;
  end

  assign unused_bits = ^{idx_full[ADDR_W-1:MEM_DEPTH], PPROT[2:1]};

  always_comb begin
    state_d  = state_q;
    setup    = 1'b0;
    pready   = 1'b0;
    complete = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          setup   = 1'b1;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        pready = (wait_q == 4'd0);
        if (!PSEL) begin
          state_d = ST_IDLE;
        end else if (PENABLE && pready) begin
          complete = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      cause_q <= ERR_NONE;
      tgt_q   <= TGT_NONE;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      if (setup) begin
        wait_q  <= 4'(WAIT_STATES);
        cause_q <= cause_d;
        tgt_q   <= tgt_d;
        wr_q    <= PWRITE;
        rdata_q <= rdata_d;
        idx_q   <= idx_d;
      end else if (state_q == ST_ACCESS && wait_q != 4'd0) begin
        wait_q <= wait_q - 4'd1;
      end
    end
  end

  assign err_q  = (cause_q != ERR_NONE);
  assign commit = complete && wr_q && !err_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      base_q    <= DATA_W'(BASE_RST);
      err_cnt_q <= '0;
    end else begin
      if (complete && err_q) begin
        if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      end else if (commit && tgt_q == TGT_ERR_CNT && |PSTRB) begin
        err_cnt_q <= '0;
      end
      if (commit && tgt_q == TGT_BASE) begin
        for (int i = 0; i < int'(BYTES); i++) begin
          if (PSTRB[i]) base_q[8*i +: 8] <= PWDATA[8*i +: 8];
        end
      end
    end
  end

  ip_amba_apb_bytemem #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (MEM_DEPTH)
  ) u_mem (
    .PCLK  (PCLK),
    .addr  (idx_q),
    .wdata (PWDATA),
    .wstrb (PSTRB),
    .we    (commit && tgt_q == TGT_MEM),
    .raddr (idx_d),
    .rdata (mem_rdata)
  );

  assign PREADY  = pready;
  assign PSLVERR = pready && err_q;
  assign PRDATA  = (pready && !wr_q && !err_q) ? rdata_q : '0;

endmodule

// File: doc/ip_amba_apb4_mem_slave.md
IP_AMBA_APB4_MEM_SLAVE -- requirements
Module: ip_amba_apb4_mem_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning PADDR width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning PWDATA/PRDATA width; legal values 8, 16, 32.
REQ-003 SHALL have parameter MEM_DEPTH, default 6, meaning log2 of the memory word count.
REQ-004 SHALL have parameter WAIT_STATES, default 0, meaning access-phase wait cycles before PREADY; legal range 0..15.
REQ-005 SHALL have parameter BASE_RST, default 'h100, meaning the reset value of the BASE register.
REQ-006 SHALL have parameter PROT_CHECK, default 1, meaning CSR writes require PPROT[0]=1 (privileged).
REQ-007 PCLK  input  1  clock, all state on rising edge.
REQ-008 PRESETn  input  1  reset, asynchronous, active-low.
REQ-009 PSEL  input  1  slave select.
REQ-010 PENABLE  input  1  access phase.
REQ-011 PWRITE  input  1  1=write, 0=read.
REQ-012 PADDR  input  ADDR_W  byte address.
REQ-013 PPROT  input  3  protection attributes.
REQ-014 PWDATA  input  DATA_W  write data.
REQ-015 PSTRB  input  DATA_W/8  write byte lanes.
REQ-016 PREADY  output  1  transfer completion.
REQ-017 PRDATA  output  DATA_W  read data.
REQ-018 PSLVERR  output  1  error response.

Function
REQ-019 Address map SHALL be: CSR BASE at 0x0 (R/W); CSR ERR_CNT at DATA_W/8 (16-bit, RO, a write clears it); memory window [BASE, BASE + 2**MEM_DEPTH*DATA_W/8 - 1].
REQ-020 CSR decode SHALL take priority over an overlapping memory window.
REQ-021 FSM SHALL have two states: IDLE and ACCESS.
REQ-022 IDLE -> ACCESS SHALL occur on PSEL=1 & PENABLE=0 (setup cycle); the wait counter SHALL load WAIT_STATES at that edge.
REQ-023 In ACCESS, PREADY SHALL be 1 iff counter==0; the counter SHALL decrement each cycle while nonzero.
REQ-024 Completion SHALL be ACCESS & PSEL & PENABLE & PREADY; the next state SHALL be IDLE.
REQ-025 A back-to-back setup in the cycle after completion SHALL be accepted, giving a 2+WAIT_STATES cycle transfer.
REQ-026 In ACCESS with PSEL=0, the transfer SHALL abort to IDLE with no write and no ERR_CNT change.
REQ-027 PENABLE=1 in IDLE without a preceding setup SHALL be ignored.
REQ-028 Error SHALL be decided in the setup cycle and registered; causes: unmapped address, PADDR low log2(DATA_W/8) bits nonzero, or CSR write with PROT_CHECK=1 & PPROT[0]=0.
REQ-029 PSLVERR SHALL equal registered error & PREADY, and SHALL be 0 otherwise.
REQ-030 Erroring writes SHALL not modify any state except ERR_CNT.
REQ-031 ERR_CNT SHALL increment by 1 at each erroring completion and saturate at 16'hFFFF.
REQ-032 Read data SHALL be captured from CSR or memory at the setup edge.
REQ-033 PRDATA SHALL equal captured data when PREADY & !PWRITE & !error, and 0 otherwise.
REQ-034 Writes SHALL commit at the completion edge, per byte lane where PSTRB[i]=1.
REQ-035 PSTRB=0 SHALL complete with no write and no error.
REQ-036 Memory index SHALL be (PADDR - BASE) >> log2(DATA_W/8), computed at ADDR_W width.
REQ-037 A BASE value where BASE + window size overflows ADDR_W SHALL map only addresses up to 2**ADDR_W - 1, with no wrap.
REQ-038 A write to BASE SHALL take effect for the next transfer's decode.

Reset
REQ-039 PRESETn low SHALL immediately force IDLE, counter 0, PREADY 0, PSLVERR 0, PRDATA 0, error flag 0, BASE to BASE_RST, and ERR_CNT to 0.
REQ-040 Memory contents SHALL not be reset.
REQ-041 Reset mid-transfer SHALL discard the transfer with no write.

Structure
REQ-042 Package ip_amba_apb_pkg SHALL hold the state enum, CSR offsets, and the error-cause encoding.
REQ-043 The byte-enable RAM SHALL be sub-module ip_amba_apb_bytemem, with write port (addr, wdata, wstrb, we) and asynchronous read port.

Verification
REQ-044 WAIT_STATES=0: write 0xDEADBEEF to BASE_RST, read back -> PREADY in the first access cycle, PRDATA=0xDEADBEEF, PSLVERR=0.
REQ-045 WAIT_STATES=3: read -> PREADY low for 3 access cycles and high on the 4th; PRDATA=0 before completion.
REQ-046 Write 0x11223344 then PSTRB=4'b0101 with 0xAABBCCDD -> readback 0x11BB33DD.
REQ-047 Read addr 0x8000 (unmapped), then CSR write with PPROT=0 -> both PSLVERR=1, BASE unchanged, ERR_CNT=2; write ERR_CNT -> reads 0.
REQ-048 Write BASE=0x400, then access 0x400 -> memory word 0; access 0x100 -> PSLVERR=1.
REQ-049 PRESETn low during ACCESS of a write -> PREADY=0 at once, target word unchanged, BASE=BASE_RST.
